// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the mult/div sequencer: state encoding, op codes,
// and the counter-width helper used by the top and its counter.
package multdiv_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Wide enough for the larger of the two reload values; never narrower than 1 bit.
  function automatic int counterWidth(input int multCycles, input int divCycles);
    int maxCycles;
    maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
    return (maxCycles <= 1) ? 1 : $clog2(maxCycles);
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Control-unit <-> sequencer signal bundle, plus the FSM state for observation.
interface multdiv_sequencer_if;
  import multdiv_defs::*;

  // Handshake: start is a one-cycle request honoured only while busy is low;
  // a request seen while busy is dropped, never queued. done or divZeroExc
  // pulses for one cycle to close an accepted request, and busy falls on the
  // next cycle, when a new start may already be presented.
  logic   start;
  logic   op;
  logic   abort;
  logic   divisorZero;
  logic   multOP;
  logic   divOP;
  logic   MultDiv;
  logic   HiLow;
  logic   busy;
  logic   done;
  logic   divZeroExc;
  state_t dbgState;

  modport master (
    output start, op, abort, divisorZero,
    input  multOP, divOP, MultDiv, HiLow, busy, done, divZeroExc, dbgState
  );

  modport slave (
    input  start, op, abort, divisorZero,
    output multOP, divOP, MultDiv, HiLow, busy, done, divZeroExc, dbgState
  );

endinterface

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Loadable down-counter that parks at zero; only a load moves it off zero.
module cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one multiply or divide through the shared datapath and commits
// the result to HI/LO; outputs decode only from registered state.
module multdiv_sequencer
  import multdiv_defs::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input logic                 clk,
  input logic                 reset,
  multdiv_sequencer_if.slave  bus
);

  localparam int CNT_W = counterWidth(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           nextState;
  logic             opReg;
  logic             acceptStart;
  logic             cntLoad;
  logic [CNT_W-1:0] cntLoadValue;
  logic             cntEn;
  logic             cntZero;
  logic             multOP;
  logic             divOP;
  logic             hiLow;
  logic             done;
  logic             divZeroExc;

  cycle_counter #(.WIDTH(CNT_W)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .en        (cntEn),
    .zero      (cntZero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opReg <= 1'b0;
    end else begin
      state <= nextState;
      if (acceptStart) begin
        opReg <= bus.op;
      end
    end
  end

  always_comb begin
    nextState    = state;
    acceptStart  = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = '0;
    cntEn        = 1'b0;
    multOP       = 1'b0;
    divOP        = 1'b0;
    hiLow        = 1'b0;
    done         = 1'b0;
    divZeroExc   = 1'b0;

    case (state)
      IDLE: begin
        // abort outranks a simultaneous start
        if (bus.start && !bus.abort) begin
          acceptStart = 1'b1;
          if (bus.op == OP_DIV) begin
            nextState = CHECK;
          end else begin
            nextState    = RUN;
            cntLoad      = 1'b1;
            cntLoadValue = MULT_LOAD;
          end
        end
      end
      CHECK: begin
        if (bus.abort) begin
          nextState = IDLE;
        end else if (bus.divisorZero) begin
          nextState = EXC;
        end else begin
          nextState    = RUN;
          cntLoad      = 1'b1;
          cntLoadValue = DIV_LOAD;
        end
      end
      RUN: begin
        multOP = ~opReg;
        divOP  = opReg;
        if (bus.abort) begin
          nextState = IDLE;
        end else if (cntZero) begin
          nextState = WRITE;
        end else begin
          cntEn = 1'b1;
        end
      end
      WRITE: begin
        hiLow     = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      EXC: begin
        divZeroExc = 1'b1;
        nextState  = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign bus.multOP     = multOP;
  assign bus.divOP      = divOP;
  assign bus.MultDiv    = opReg;
  assign bus.HiLow      = hiLow;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;
  assign bus.divZeroExc = divZeroExc;
  assign bus.dbgState   = state;

endmodule
